ball_ctrl: RTL

- Game-tick scheduler for the 4-player 8x8 pong field.
- Owns the ball position and direction, and advances the ball one cell per game tick.
- Presents each new position to the paddle contact checker, waits out the checker's latency, then samples `contact`.
- On a paddle hit it reflects the direction; on a miss it reports a goal and re-serves from centre.

---
 rtl/pong_pkg.sv | 31 +++
 rtl/tick_div.sv | 40 ++++
 rtl/ball_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the 4-player 8x8 pong field.
//   state_t      - ball_ctrl FSM states
//   SIDE_*       - goal_side codes (0 top, 1 down, 2 left, 3 right)
//   CENTER_POS   - serve position {x, y} = (3, 3)
//   CONTACT_X/Y  - bit indices into the contact checker's 2-bit result.
//                  Bit 0 is the left/right paddle (x axis), bit 1 is the
//                  top/down paddle (y axis).
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_WAIT_TICK,
        ST_MOVE,
        ST_CHECK,
        ST_DECIDE,
        ST_GOAL
    } state_t;

    localparam logic [1:0] SIDE_TOP   = 2'd0;
    localparam logic [1:0] SIDE_DOWN  = 2'd1;
    localparam logic [1:0] SIDE_LEFT  = 2'd2;
    localparam logic [1:0] SIDE_RIGHT = 2'd3;

    localparam logic [5:0] CENTER_POS = 6'o33;
    localparam logic [1:0] DIR_RESET  = 2'b11;

    localparam int CONTACT_X = 0;
    localparam int CONTACT_Y = 1;

endpackage

// File: rtl/tick_div.sv
// tick_div: modulus-TICK_DIV counter with enable and synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the count this cycle
//   clr      : force the count to zero (wins over en)
//   tc       : terminal count, high while count == TICK_DIV-1
// The count wraps to zero on an enabled terminal-count cycle, so a
// continuously enabled counter asserts tc once every TICK_DIV cycles.
module tick_div #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CW       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q, count_d;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = tc ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/ball_ctrl.sv
// ball_ctrl: game-tick scheduler for the 4-player pong field.
// Owns the ball position/direction, advances one cell per game tick,
// presents the new position to the paddle contact checker, waits out its
// latency, then reflects on a hit or reports a goal and re-serves on a miss.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : level, leaves IDLE (ignored elsewhere)
//   pause      : freezes the game-tick counter while high
//   contact    : checker result, bit0 = left/right hit, bit1 = top/down hit
//   pos        : ball position {x, y}
//   pos_valid  : high while pos is presented to the checker
//   dir        : {dx, dy}, 1 = increasing coordinate
//   goal       : one-cycle pulse on a miss
//   goal_side  : side that missed, held until the next goal
//   busy       : high in every state except IDLE
module ball_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int TICK_DIV     = 4,
    parameter int CHECK_LAT    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      pause,
    input  logic [1:0]                contact,
    output logic [2*BIT_OF_WIDTH-1:0] pos,
    output logic                      pos_valid,
    output logic [1:0]                dir,
    output logic                      goal,
    output logic [1:0]                goal_side,
    output logic                      busy
);

    localparam int B = BIT_OF_WIDTH;
    localparam logic [B-1:0]   EDGE_LO  = B'(1);
    localparam logic [B-1:0]   EDGE_HI  = B'(WIDTH - 2);
    localparam logic [2*B-1:0] CENTER   = (2*B)'(CENTER_POS);
    localparam logic [2:0]     LAT_LAST = 3'(CHECK_LAT - 1);

    state_t          state_q, state_d;
    logic [2*B-1:0]  pos_q, pos_d;
    logic [1:0]      dir_q, dir_d;
    logic [1:0]      goal_side_q, goal_side_d;
    logic [1:0]      contact_q, contact_d;
    logic [2:0]      lat_q, lat_d;
    logic            goal_q, goal_d;
    logic            pos_valid_q, pos_valid_d;

    logic            tick_en, tick_clr, tick_tc;

    logic [B-1:0]    x, y;
    logic            dx, dy;
    logic            out_x, out_y, hit_x, hit_y, miss_x, miss_y;

    tick_div #(
        .TICK_DIV (TICK_DIV),
        .CW       (16)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (tick_en),
        .clr (tick_clr),
        .tc  (tick_tc)
    );

    assign x  = pos_q[2*B-1:B];
    assign y  = pos_q[B-1:0];
    assign dx = dir_q[1];
    assign dy = dir_q[0];

    // Outbound means the ball sits on the last playable cell and is still
    // heading toward the wall; only then does that axis' contact bit matter.
    assign out_x  = ((x == EDGE_LO) && !dx) || ((x == EDGE_HI) && dx);
    assign out_y  = ((y == EDGE_LO) && !dy) || ((y == EDGE_HI) && dy);
    assign hit_x  = out_x &&  contact_q[CONTACT_X];
    assign hit_y  = out_y &&  contact_q[CONTACT_Y];
    assign miss_x = out_x && !contact_q[CONTACT_X];
    assign miss_y = out_y && !contact_q[CONTACT_Y];

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        goal_side_d = goal_side_q;
        contact_d   = contact_q;
        lat_d       = lat_q;
        tick_en     = 1'b0;
        tick_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pos_d   = CENTER;
                    state_d = ST_SERVE;
                end
            end

            ST_SERVE: begin
                pos_d    = CENTER;
                tick_clr = 1'b1;
                state_d  = ST_WAIT_TICK;
            end

            ST_WAIT_TICK: begin
                tick_en = !pause;
                if (tick_tc && !pause)
                    state_d = ST_MOVE;
            end

            ST_MOVE: begin
                pos_d[2*B-1:B] = dx ? x + B'(1) : x - B'(1);
                pos_d[B-1:0]   = dy ? y + B'(1) : y - B'(1);
                lat_d          = '0;
                state_d        = ST_CHECK;
            end

            ST_CHECK: begin
                if (lat_q == LAT_LAST) begin
                    contact_d = contact;
                    lat_d     = '0;
                    state_d   = ST_DECIDE;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end

            ST_DECIDE: begin
                // Hits reflect even when the other axis misses.
                if (hit_x) dir_d[1] = ~dx;
                if (hit_y) dir_d[0] = ~dy;
                // In a double-miss corner the left/right side is reported.
                if (miss_x) begin
                    goal_side_d = (x == EDGE_LO) ? SIDE_LEFT : SIDE_RIGHT;
                    state_d     = ST_GOAL;
                end else if (miss_y) begin
                    goal_side_d = (y == EDGE_LO) ? SIDE_TOP : SIDE_DOWN;
                    state_d     = ST_GOAL;
                end else begin
                    state_d = ST_WAIT_TICK;
                end
            end

            ST_GOAL: begin
                // Re-serve away from the reported side; other axis kept.
                case (goal_side_q)
                    SIDE_LEFT:  dir_d[1] = 1'b1;
                    SIDE_RIGHT: dir_d[1] = 1'b0;
                    SIDE_TOP:   dir_d[0] = 1'b1;
                    default:    dir_d[0] = 1'b0;
                endcase
                pos_d   = CENTER;
                state_d = ST_SERVE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pos_valid_d = (state_d == ST_CHECK);
    assign goal_d      = (state_d == ST_GOAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pos_q       <= CENTER;
            dir_q       <= DIR_RESET;
            goal_side_q <= SIDE_TOP;
            contact_q   <= '0;
            lat_q       <= '0;
            goal_q      <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            goal_side_q <= goal_side_d;
            contact_q   <= contact_d;
            lat_q       <= lat_d;
            goal_q      <= goal_d;
            pos_valid_q <= pos_valid_d;
        end
    end

    assign pos       = pos_q;
    assign dir       = dir_q;
    assign goal      = goal_q;
    assign goal_side = goal_side_q;
    assign pos_valid = pos_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
